dm_store_buffer: RTL and testbench

In-order store buffer between the memory-stage pipeline register and `dm_1k`. Stores from the CPU are queued (word `sw` or byte `sb`) and drained into the data memory one per cycle whenever the memory port is not needed by a load. Loads read `dm_1k` combinationally through this block. A load is stalled while any queued store overlaps its 4-byte read window, or while the buffer is full.

---
 rtl/dm_store_buffer.sv | 192 +++++++++++++++++++
 tb/tb_dm_store_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
//
// In-order store buffer between the memory-stage pipeline register and the
// 1 KiB data memory (dm_1k). Stores (sw / sb) are queued in a small circular
// FIFO and drained into the memory one per cycle whenever a load does not need
// the memory port. Loads read dm_1k combinationally through this block and are
// stalled while any older store (queued, or being pushed this very cycle)
// overlaps their 4-byte read window, or while the buffer is full.
//
// Handshakes:
//   store side : a store is accepted on a rising edge where st_valid && st_ready.
//                While st_ready is low the pipeline holds st_* stable.
//   load side  : a load completes in any cycle where ld_valid && !ld_stall; the
//                read data is dm_1k.dout in that same cycle. While ld_stall is
//                high the pipeline holds ld_valid / ld_addr stable.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   st_valid / st_ready store request / buffer has a free entry
//   st_byte             1 = sb (st_data[7:0] at st_addr), 0 = sw (4 bytes)
//   st_addr, st_data    store byte address and data
//   ld_valid, ld_addr   load request and byte address
//   ld_stall            load must be held this cycle
//   dm_addr, dm_din     memory port address and write data
//   dm_we, dm_sb        word-store / byte-store strobes (mutually exclusive)
//   count, empty        number of queued stores, count == 0
// -----------------------------------------------------------------------------
module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic                     st_byte,
   input  logic [AW-1:0]            st_addr,
   input  logic [31:0]              st_data,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_addr,
   output logic                     ld_stall,
   output logic [AW-1:0]            dm_addr,
   output logic [31:0]              dm_din,
   output logic                     dm_we,
   output logic                     dm_sb,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic [DEPTH-1:0] ent_byte_q, ent_byte_d;
   logic [AW-1:0]    ent_addr_q [DEPTH];
   logic [AW-1:0]    ent_addr_d [DEPTH];
   logic [31:0]      ent_data_q [DEPTH];
   logic [31:0]      ent_data_d [DEPTH];

   // ---------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------
   logic             full;
   logic             push;
   logic             pop;
   logic             ld_own;
   logic             conflict;
   logic             push_hit;
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] hit_vec;
   logic [PW-1:0]    slot_off;

   // Two windows on a 2^AW byte ring intersect exactly when the start of one
   // lies inside the other. Modular subtraction makes the wrap at the top of
   // memory fall out naturally, matching how dm_1k wraps its byte lanes.
   function automatic logic win_overlap(
      input logic [AW-1:0] la,
      input logic [AW-1:0] sa,
      input logic          sb_flag
   );
      logic [AW-1:0] st_off;
      logic [AW-1:0] ld_off;
      st_off = sa - la;
      ld_off = la - sa;
      return (st_off < AW'(4)) || (!sb_flag && (ld_off < AW'(4)));
   endfunction

   assign full     = (count_q == CW'(DEPTH));
   assign st_ready = !full;
   assign push     = st_valid && st_ready;

   // Slot i is live when its distance from head (mod DEPTH) is below count.
   always_comb begin
      valid_vec = '0;
      hit_vec   = '0;
      slot_off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off     = PW'(i) - head_q;
         valid_vec[i] = ({1'b0, slot_off} < count_q);
         hit_vec[i]   = win_overlap(ld_addr, ent_addr_q[i], ent_byte_q[i]);
      end
   end

   // A store pushed in the same cycle is older than the load in program order,
   // so it must be visible to the load as well.
   assign push_hit = push && win_overlap(ld_addr, st_addr, st_byte);
   assign conflict = ld_valid && ((|(valid_vec & hit_vec)) || push_hit);

   // Port arbitration. A full buffer always drains so stores cannot starve.
   assign ld_own = ld_valid && !conflict && !full;
   assign pop    = !ld_own && (count_q != '0);

   // A load that does not own the port is held. This also covers the case of
   // an empty buffer with an overlapping store pushed this cycle: the port is
   // idle, but the load must wait for that store to drain first.
   assign ld_stall = ld_valid && !ld_own;

   always_comb begin
      dm_addr = ld_addr;
      dm_din  = '0;
      dm_we   = 1'b0;
      dm_sb   = 1'b0;
      if (pop) begin
         dm_addr = ent_addr_q[head_q];
         dm_din  = ent_data_q[head_q];
         dm_we   = !ent_byte_q[head_q];
         dm_sb   = ent_byte_q[head_q];
      end
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      ent_byte_d = ent_byte_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;

      if (push) begin
         ent_byte_d[tail_q] = st_byte;
         ent_addr_d[tail_q] = st_addr;
         ent_data_d[tail_q] = st_data;
         tail_d             = tail_q + PW'(1);
      end

      if (pop) begin
         head_d = head_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ent_byte_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ent_byte_q <= ent_byte_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= ent_addr_d[i];
            ent_data_q[i] <= ent_data_d[i];
         end
      end
   end

   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: tb/tb_dm_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_store_buffer
//
// Bench for dm_store_buffer with a behavioural dm_1k (combinational read,
// write on the rising edge, byte addresses wrapping at 1 KiB, little endian).
// A reference byte image is updated in program order whenever a store is
// accepted; every completed load is compared with it, and every drain is
// compared in order against the expected-store queue.
// -----------------------------------------------------------------------------
module tb_dm_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------------
   logic          st_valid, st_ready, st_byte;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic          ld_valid, ld_stall;
   logic [AW-1:0] ld_addr;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_din;
   logic          dm_we, dm_sb;
   logic [2:0]    count;
   logic          empty;

   dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .st_valid (st_valid),
      .st_ready (st_ready),
      .st_byte  (st_byte),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_stall (ld_stall),
      .dm_addr  (dm_addr),
      .dm_din   (dm_din),
      .dm_we    (dm_we),
      .dm_sb    (dm_sb),
      .count    (count),
      .empty    (empty)
   );

   // ---------------------------------------------------------------------------
   // Behavioural dm_1k
   // ---------------------------------------------------------------------------
   logic [7:0]  mem [0:1023];
   logic [31:0] dm_dout;
   logic        mem_clr;

   assign dm_dout = {mem[10'(dm_addr + 10'd3)], mem[10'(dm_addr + 10'd2)],
                     mem[10'(dm_addr + 10'd1)], mem[dm_addr]};

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
      end else begin
         if (dm_we) begin
            mem[dm_addr]                <= dm_din[7:0];
            mem[10'(dm_addr + 10'd1)]   <= dm_din[15:8];
            mem[10'(dm_addr + 10'd2)]   <= dm_din[23:16];
            mem[10'(dm_addr + 10'd3)]   <= dm_din[31:24];
         end
         if (dm_sb) mem[dm_addr] <= dm_din[7:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard state and checker
   // ---------------------------------------------------------------------------
   logic [42:0] exp_q [$];
   logic [7:0]  ref_mem [0:1023];
   logic        track;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_drains = 0;
   int          drains_snap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] ref_word(input logic [9:0] a);
      return {ref_mem[10'(a + 10'd3)], ref_mem[10'(a + 10'd2)],
              ref_mem[10'(a + 10'd1)], ref_mem[a]};
   endfunction

   // Sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;
      end else if (rst_n) begin
         if (dm_we || dm_sb) begin
            n_drains++;
            check("strobe_excl", 64'(dm_we && dm_sb), 64'(0));
            check("drain_queued", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0)
               check("drain_order", 64'({dm_sb, dm_addr, dm_din}), 64'(exp_q.pop_front()));
         end
         if (ld_valid && !ld_stall) begin
            check("ld_port_addr", 64'(dm_addr), 64'(ld_addr));
            check("ld_data", 64'(dm_dout), 64'(ref_word(ld_addr)));
         end
         if (track && st_valid && st_ready) begin
            exp_q.push_back({st_byte, st_addr, st_data});
            if (st_byte) begin
               ref_mem[st_addr] = st_data[7:0];
            end else begin
               ref_mem[st_addr]              = st_data[7:0];
               ref_mem[10'(st_addr + 10'd1)] = st_data[15:8];
               ref_mem[10'(st_addr + 10'd2)] = st_data[23:16];
               ref_mem[10'(st_addr + 10'd3)] = st_data[31:24];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic drive_store(input logic b, input logic [AW-1:0] a, input logic [31:0] d);
      st_valid = 1'b1;
      st_byte  = b;
      st_addr  = a;
      st_data  = d;
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 40 && count != 3'd0; i++) next_cycle();
      to_neg();
      check(tag, 64'(count), 64'(0));
      next_cycle();
   endtask

   // Watchdog: a hung run still reports.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic st_blocked, ld_blocked;

   initial begin
      st_valid = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0;
      ld_valid = 1'b0; ld_addr = 10'h155;
      rst_n = 1'b0; track = 1'b1; mem_clr = 1'b1;
      repeat (2) @(posedge clk);

      // Reset values
      to_neg();
      check("rst_count", 64'(count), 64'(0));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_st_ready", 64'(st_ready), 64'(1));
      check("rst_dm_we", 64'(dm_we), 64'(0));
      check("rst_dm_sb", 64'(dm_sb), 64'(0));
      check("rst_dm_din", 64'(dm_din), 64'(0));
      check("rst_dm_addr", 64'(dm_addr), 64'(10'h155));
      check("rst_ld_stall", 64'(ld_stall), 64'(0));
      mem_clr = 1'b0;
      rst_n   = 1'b1;
      next_cycle();

      // sw then drain, then load back
      drive_store(1'b0, 10'h010, 32'h1122_3344);
      to_neg();
      check("t1_st_ready", 64'(st_ready), 64'(1));
      next_cycle();
      st_valid = 1'b0;
      to_neg();
      check("t1_dm_we", 64'(dm_we), 64'(1));
      check("t1_dm_addr", 64'(dm_addr), 64'(10'h010));
      check("t1_dm_din", 64'(dm_din), 64'(32'h1122_3344));
      check("t1_count", 64'(count), 64'(1));
      next_cycle();
      ld_valid = 1'b1; ld_addr = 10'h010;
      to_neg();
      check("t1_count_after", 64'(count), 64'(0));
      check("t1_ld_stall", 64'(ld_stall), 64'(0));
      check("t1_ld_word", 64'(dm_dout), 64'(32'h1122_3344));
      next_cycle();
      ld_valid = 1'b0;

      // sb then overlapping load
      drive_store(1'b1, 10'h021, 32'h5A5A_00AB);
      next_cycle();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 10'h020;
      to_neg();
      check("t2_ld_stall", 64'(ld_stall), 64'(1));
      check("t2_dm_sb", 64'(dm_sb), 64'(1));
      check("t2_dm_we", 64'(dm_we), 64'(0));
      check("t2_dm_addr", 64'(dm_addr), 64'(10'h021));
      next_cycle();
      to_neg();
      check("t2_unstall", 64'(ld_stall), 64'(0));
      check("t2_byte1", 64'(dm_dout[15:8]), 64'(8'hAB));
      next_cycle();
      ld_valid = 1'b0;

      // Loads every cycle while filling the buffer
      drains_snap = n_drains;
      ld_valid = 1'b1; ld_addr = 10'h100;
      for (int i = 0; i < 4; i++) begin
         drive_store(1'b0, 10'(i * 4), $urandom);
         to_neg();
         check("t3_ld_owns", 64'(ld_stall), 64'(0));
         next_cycle();
      end
      st_valid = 1'b0;
      to_neg();
      check("t3_count_full", 64'(count), 64'(4));
      check("t3_st_ready", 64'(st_ready), 64'(0));
      check("t3_ld_stall", 64'(ld_stall), 64'(1));
      check("t3_dm_we", 64'(dm_we), 64'(1));
      check("t3_dm_addr", 64'(dm_addr), 64'(10'h000));
      next_cycle();
      ld_valid = 1'b0;
      wait_empty("t3_drained");
      check("t3_drain_cnt", 64'(n_drains - drains_snap), 64'(4));

      // Window wrap at the top of memory
      drive_store(1'b0, 10'h3FE, 32'hDEAD_BEEF);
      next_cycle();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 10'h000;
      to_neg();
      check("t4_ld_stall", 64'(ld_stall), 64'(1));
      check("t4_dm_we", 64'(dm_we), 64'(1));
      check("t4_dm_addr", 64'(dm_addr), 64'(10'h3FE));
      next_cycle();
      to_neg();
      check("t4_unstall", 64'(ld_stall), 64'(0));
      check("t4_low16", 64'(dm_dout[15:0]), 64'(16'hDEAD));
      next_cycle();
      ld_valid = 1'b0;

      // Simultaneous store and overlapping load on an empty buffer
      drive_store(1'b0, 10'h040, 32'hCAFE_F00D);
      ld_valid = 1'b1; ld_addr = 10'h042;
      to_neg();
      check("t5_ld_stall", 64'(ld_stall), 64'(1));
      check("t5_st_ready", 64'(st_ready), 64'(1));
      check("t5_dm_we_idle", 64'(dm_we), 64'(0));
      next_cycle();
      st_valid = 1'b0;
      to_neg();
      check("t5_stall_drain", 64'(ld_stall), 64'(1));
      check("t5_dm_we", 64'(dm_we), 64'(1));
      next_cycle();
      to_neg();
      check("t5_unstall", 64'(ld_stall), 64'(0));
      check("t5_low16", 64'(dm_dout[15:0]), 64'(16'hCAFE));
      next_cycle();
      ld_valid = 1'b0;

      // Asynchronous reset with three pending stores
      track = 1'b0;
      drains_snap = n_drains;
      ld_valid = 1'b1; ld_addr = 10'h200;
      for (int i = 0; i < 3; i++) begin
         drive_store(1'b0, 10'(10'h300 + 10'(i * 4)), $urandom | 32'h1);
         next_cycle();
      end
      st_valid = 1'b0;
      #1;
      check("t6_count_pre", 64'(count), 64'(3));
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_count", 64'(count), 64'(0));
      check("t6_empty", 64'(empty), 64'(1));
      check("t6_dm_we", 64'(dm_we), 64'(0));
      check("t6_dm_sb", 64'(dm_sb), 64'(0));
      check("t6_st_ready", 64'(st_ready), 64'(1));
      ld_valid = 1'b0;
      next_cycle();
      to_neg();
      rst_n = 1'b1;
      track = 1'b1;
      repeat (6) next_cycle();
      to_neg();
      check("t6_no_drain", 64'(n_drains - drains_snap), 64'(0));
      check("t6_count_idle", 64'(count), 64'(0));
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_addr = 10'(10'h300 + 10'(i * 4));
         to_neg();
         check("t6_mem_clean", 64'(dm_dout), 64'(0));
         next_cycle();
      end
      ld_valid = 1'b0;

      // Random mix: held stores/loads, byte and word, windows near the wrap
      for (int i = 0; i < 300; i++) begin
         to_neg();
         st_blocked = st_valid && !st_ready;
         ld_blocked = ld_valid && ld_stall;
         next_cycle();
         if (!st_blocked) begin
            st_valid = ($urandom_range(0, 2) != 0);
            st_byte  = 1'($urandom_range(0, 1));
            st_addr  = (($urandom_range(0, 1) != 0) ? 10'h080 : 10'h3F8) + 10'($urandom_range(0, 15));
            st_data  = $urandom;
         end
         if (!ld_blocked) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = (($urandom_range(0, 1) != 0) ? 10'h080 : 10'h3F8) + 10'($urandom_range(0, 15));
         end
      end
      st_valid = 1'b0;
      ld_valid = 1'b0;
      wait_empty("rand_drained");
      check("sb_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
